// File: rtl/seq_mult4_pkg.sv
// rtl/seq_mult4_pkg.sv - shared state encoding and default width for seq_mult4
package seq_mult4_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult4_if.sv
// rtl/seq_mult4_if.sv - start/busy/done handshake and operand/product bus
interface seq_mult4_if
  import seq_mult4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic                 start;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic [2*WIDTH-1:0]   product;
  logic                 prod_we;
  logic                 busy;
  logic                 done;

  modport master (
    output start, a_in, b_in,
    input  product, prod_we, busy, done
  );

  modport slave (
    input  start, a_in, b_in,
    output product, prod_we, busy, done
  );

endinterface

// File: rtl/seq_mult4_ctrl.sv
// rtl/seq_mult4_ctrl.sv - IDLE/RUN/DONE sequencer with iteration counter
module seq_mult4_ctrl
  import seq_mult4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   res,
  input  logic                                   start_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   prod_we_o,
  output logic                                   load_o,
  output logic                                   run_o,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] idx_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;

  // busy/done are registered alongside the state so they stay pure Moore outputs
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign load_o    = (state_q == S_IDLE) && start_i;
  assign run_o     = (state_q == S_RUN);
  assign idx_o     = cnt_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign prod_we_o = done_q;

endmodule

// File: rtl/seq_mult4.sv
// rtl/seq_mult4.sv - shift-add unsigned multiplier: operand registers and accumulator
module seq_mult4
  import seq_mult4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic        clk,
  input  logic        res,
  seq_mult4_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  logic             load;
  logic             run;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    acc_d;

  seq_mult4_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk       (clk),
    .res       (res),
    .start_i   (bus.start),
    .busy_o    (bus.busy),
    .done_o    (bus.done),
    .prod_we_o (bus.prod_we),
    .load_o    (load),
    .run_o     (run),
    .idx_o     (idx)
  );

  // the product of two WIDTH-bit values always fits in PW bits, so no carry is lost
  assign acc_d = acc_q + (PW'(a_q) << idx);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (load) begin
      a_q   <= bus.a_in;
      b_q   <= bus.b_in;
      acc_q <= '0;
    end else if (run && b_q[idx]) begin
      acc_q <= acc_d;
    end
  end

  assign bus.product = acc_q;

endmodule

// File: tb/tb_seq_mult4.sv
// tb/tb_seq_mult4.sv - self-checking bench for seq_mult4 against an arithmetic reference
module tb_seq_mult4;

  localparam int W = 4;

  logic clk = 1'b0;
  logic res = 1'b0;
  int   passed = 0;
  int   total  = 0;
  int   exp_q[$];

  seq_mult4_if #(.WIDTH(W)) bus ();

  seq_mult4 #(.WIDTH(W)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_outs(input string tag, input int p, input bit b, input bit d);
    chk({tag, ".product"}, 32'(bus.product), p);
    chk({tag, ".busy"},    32'(bus.busy),    32'(b));
    chk({tag, ".done"},    32'(bus.done),    32'(d));
    chk({tag, ".prod_we"}, 32'(bus.prod_we), 32'(d));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One operation: accepted at the first edge, DONE visible in the 5th sampled cycle,
  // idle again in the 6th. Optionally pokes a 3x3 start while RUN to show it is ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    int prod;
    prod = int'(a) * int'(b);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.a_in  = W'($urandom_range(15));
    bus.b_in  = W'($urandom_range(15));
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("op%0dx%0d.c%0d.busy", a, b, c), 32'(bus.busy), 1);
      chk($sformatf("op%0dx%0d.c%0d.done", a, b, c), 32'(bus.done), 32'(c == 5));
      chk($sformatf("op%0dx%0d.c%0d.we", a, b, c), 32'(bus.prod_we), 32'(c == 5));
      if (c == 1) chk($sformatf("op%0dx%0d.cleared", a, b), 32'(bus.product), 0);
      if (c == 5) chk($sformatf("op%0dx%0d.product", a, b), 32'(bus.product), prod);
      if (poke && c == 2) begin
        bus.a_in  = 4'd3;
        bus.b_in  = 4'd3;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      step();
    end
    chk_outs($sformatf("op%0dx%0d.after", a, b), prod, 1'b0, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;

    // reset held for two cycles, then idle
    step();
    chk_outs("rst.c1", 0, 1'b0, 1'b0);
    step();
    chk_outs("rst.c2", 0, 1'b0, 1'b0);
    @(negedge clk);
    res = 1'b1;
    step();
    chk_outs("idle.c1", 0, 1'b0, 1'b0);
    step();
    chk_outs("idle.c2", 0, 1'b0, 1'b0);

    // directed products, including a zero operand with full latency
    run_op(4'd15, 4'd15, 1'b0);
    step();
    chk_outs("hold225", 225, 1'b0, 1'b0);
    run_op(4'd10, 4'd12, 1'b0);
    run_op(4'd1,  4'd9,  1'b0);
    run_op(4'd0,  4'd13, 1'b0);

    // start during RUN is ignored
    run_op(4'd5, 4'd6, 1'b1);

    // asynchronous reset mid-operation
    bus.a_in  = 4'd9;
    bus.b_in  = 4'd9;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    #2;
    res = 1'b0;
    #1;
    chk_outs("async_rst", 0, 1'b0, 1'b0);
    @(negedge clk);
    res = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk_outs($sformatf("post_rst.c%0d", c), 0, 1'b0, 1'b0);
    end
    run_op(4'd7, 4'd6, 1'b0);

    // randomized single operations
    for (int n = 0; n < 12; n++) begin
      run_op(W'($urandom_range(15)), W'($urandom_range(15)), 1'($urandom_range(1)));
    end

    // start held high: an accepted start every 6 edges, operands change each cycle
    bus.start = 1'b1;
    for (int k = 0; k < 48; k++) begin
      bus.a_in = W'($urandom_range(15));
      bus.b_in = W'($urandom_range(15));
      if (k % 6 == 0) exp_q.push_back(int'(bus.a_in) * int'(bus.b_in));
      step();
      chk($sformatf("b2b.k%0d.busy", k), 32'(bus.busy), 32'(k % 6 != 5));
      chk($sformatf("b2b.k%0d.done", k), 32'(bus.done), 32'(k % 6 == 4));
      if (k % 6 == 4) chk($sformatf("b2b.k%0d.product", k), 32'(bus.product), exp_q.pop_front());
    end
    bus.start = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
